// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Front-end conditioner for six raw push-buttons (up, down,
//                left, right, mode, set). Each button is synchronised,
//                debounced and converted into registered single-cycle press
//                pulses. Up and down additionally auto-repeat while held.
//
//  Ports       : i_clk        - clock
//                i_rstn       - asynchronous active-low reset
//                i_*_raw      - raw asynchronous buttons, 1 = pressed
//                o_up..o_set  - registered single-cycle press pulses
//                o_held[5:0]  - debounced levels {set,mode,right,left,down,up}
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_up_raw,
    input  logic       i_down_raw,
    input  logic       i_left_raw,
    input  logic       i_right_raw,
    input  logic       i_mode_raw,
    input  logic       i_set_raw,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_mode,
    output logic       o_set,
    output logic [5:0] o_held
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_NUM_CH = 6;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int C_CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Hold counter is shared between the delay and period phases, so it is
    // sized for the larger of the two terminal values.
    localparam int C_RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_HCNT_W = (C_RMAX > 1) ? $clog2(C_RMAX) : 1;

    localparam logic [C_CNT_W-1:0]  C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_HCNT_W-1:0] C_DLY_MAX = C_HCNT_W'(REPEAT_DELAY - 1);
    localparam logic [C_HCNT_W-1:0] C_PER_MAX = C_HCNT_W'(REPEAT_PERIOD - 1);

    // Auto-repeat states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    // ------------------------------------------------------------------------
    // Channel bundling: index 0 = up ... index 5 = set
    // ------------------------------------------------------------------------
    logic [C_NUM_CH-1:0] w_raw;
    logic [C_NUM_CH-1:0] w_pulse;
    logic [C_NUM_CH-1:0] w_held;

    assign w_raw = {i_set_raw, i_mode_raw, i_right_raw, i_left_raw, i_down_raw, i_up_raw};

    // ------------------------------------------------------------------------
    // Per-channel conditioning
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < C_NUM_CH; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_sync;
        logic                   r_db;
        logic [C_CNT_W-1:0]     r_cnt;
        logic                   w_accept;
        logic                   w_rise;
        logic                   w_rep;
        logic                   r_pulse;

        // --------------------------------------------------------------------
        // Synchroniser chain; bit 0 samples the raw pin
        // --------------------------------------------------------------------
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
            end
        end

        assign w_sync = r_sync[SYNC_STAGES-1];

        // --------------------------------------------------------------------
        // Debouncer: a level change is accepted only after the synchronised
        // input has disagreed with the accepted level on DEBOUNCE_CYCLES
        // consecutive edges. Any agreement restarts the count, so the counter
        // stops at its terminal value and never wraps.
        // --------------------------------------------------------------------
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else if (w_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_db  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Level change being accepted on this edge
        assign w_accept = (w_sync != r_db) && (r_cnt == C_CNT_MAX);
        // Press: accepted 0->1. The pulse flop is loaded on the same edge as
        // r_db so the pulse and o_held rise together.
        assign w_rise   = w_accept && w_sync;

        // --------------------------------------------------------------------
        // Auto-repeat (up and down only)
        // --------------------------------------------------------------------
        if (ch < 2) begin : g_repeat

            rep_state_t            r_state;
            rep_state_t            w_state_nxt;
            logic [C_HCNT_W-1:0]   r_hcnt;
            logic [C_HCNT_W-1:0]   w_hcnt_nxt;
            logic                  w_fire;
            logic                  w_fall;

            // Release: accepted 1->0
            assign w_fall = w_accept && !w_sync;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_state <= S_IDLE;
                    r_hcnt  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_hcnt  <= w_hcnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_hcnt_nxt  = r_hcnt;
                w_fire      = 1'b0;

                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            w_state_nxt = S_DELAY;
                            w_hcnt_nxt  = '0;
                        end
                    end

                    S_DELAY: begin
                        if (r_hcnt == C_DLY_MAX) begin
                            w_fire      = 1'b1;
                            w_hcnt_nxt  = '0;
                            w_state_nxt = S_REPEAT;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + 1'b1;
                        end
                    end

                    S_REPEAT: begin
                        if (r_hcnt == C_PER_MAX) begin
                            w_fire      = 1'b1;
                            w_hcnt_nxt  = '0;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + 1'b1;
                        end
                    end

                    default: begin
                        w_state_nxt = S_IDLE;
                        w_hcnt_nxt  = '0;
                    end
                endcase

                // A release overrides everything, including a repeat pulse
                // that happens to fall due on the same edge.
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    w_hcnt_nxt  = '0;
                    w_fire      = 1'b0;
                end
            end

            assign w_rep = w_fire;

        end else begin : g_no_repeat

            assign w_rep = 1'b0;

        end

        // --------------------------------------------------------------------
        // Output pulse register: press and repeat never coincide because a
        // press is only accepted while the repeat FSM is idle.
        // --------------------------------------------------------------------
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_rise | w_rep;
            end
        end

        assign w_pulse[ch] = r_pulse;
        assign w_held[ch]  = r_db;

    end

    // ------------------------------------------------------------------------
    // Outputs (all directly from flops)
    // ------------------------------------------------------------------------
    assign o_up    = w_pulse[0];
    assign o_down  = w_pulse[1];
    assign o_left  = w_pulse[2];
    assign o_right = w_pulse[3];
    assign o_mode  = w_pulse[4];
    assign o_set   = w_pulse[5];
    assign o_held  = w_held;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner using
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//                REPEAT_PERIOD=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int C_SYNC = 2;
    localparam int C_DEB  = 4;
    localparam int C_RDLY = 10;
    localparam int C_RPER = 3;
    localparam int C_LAT  = C_SYNC + C_DEB;

    logic       clk;
    logic       rstn;
    logic       up_raw, down_raw, left_raw, right_raw, mode_raw, set_raw;
    logic       o_up, o_down, o_left, o_right, o_mode, o_set;
    logic [5:0] o_held;
    logic [5:0] pulses;

    assign pulses = {o_set, o_mode, o_right, o_left, o_down, o_up};

    button_conditioner #(
        .SYNC_STAGES    (C_SYNC),
        .DEBOUNCE_CYCLES(C_DEB),
        .REPEAT_DELAY   (C_RDLY),
        .REPEAT_PERIOD  (C_RPER)
    ) u_dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_up_raw   (up_raw),
        .i_down_raw (down_raw),
        .i_left_raw (left_raw),
        .i_right_raw(right_raw),
        .i_mode_raw (mode_raw),
        .i_set_raw  (set_raw),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_left     (o_left),
        .o_right    (o_right),
        .o_mode     (o_mode),
        .o_set      (o_set),
        .o_held     (o_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;
    int pcount [6];
    int first_cyc [6];
    int up_q [$];
    int dn_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 6; i++) begin
            pcount[i]    = 0;
            first_cyc[i] = -1;
        end
        up_q.delete();
        dn_q.delete();
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 6; i++) begin
            if (pulses[i] === 1'b1) begin
                pcount[i]++;
                if (first_cyc[i] < 0) first_cyc[i] = cyc;
                if (i == 0) up_q.push_back(cyc);
                if (i == 1) dn_q.push_back(cyc);
            end
        end
    endtask

    int p;
    int c1;
    int c0;
    int rep8 [8] = '{0, 10, 13, 16, 19, 22, 25, 28};
    int rep5 [5] = '{6, 16, 19, 22, 25};

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rstn  = 1'b0;
        {up_raw, down_raw, left_raw, right_raw, mode_raw, set_raw} = '0;
        clear_stats();

        // ---------------- reset state ----------------
        repeat (3) tick();
        check_eq("rst_pulses", {26'd0, pulses}, 32'd0);
        check_eq("rst_held",   {26'd0, o_held}, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // ---------------- clean press on mode ----------------
        clear_stats();
        mode_raw = 1'b1;
        repeat (C_LAT - 1) tick();
        check_eq("mode_early", {31'd0, o_mode}, 32'd0);
        check_eq("mode_held_early", {31'd0, o_held[4]}, 32'd0);
        tick();
        check_eq("mode_pulse", {31'd0, o_mode}, 32'd1);
        check_eq("mode_held_rise", {31'd0, o_held[4]}, 32'd1);
        tick();
        check_eq("mode_pulse_end", {31'd0, o_mode}, 32'd0);
        repeat (40 - C_LAT - 1) tick();
        mode_raw = 1'b0;
        repeat (C_LAT - 1) tick();
        check_eq("mode_held_before_fall", {31'd0, o_held[4]}, 32'd1);
        tick();
        check_eq("mode_held_fall", {31'd0, o_held[4]}, 32'd0);
        repeat (4) tick();
        check_eq("mode_count", pcount[4], 32'd1);
        check_eq("mode_others", pcount[0] + pcount[1] + pcount[2] + pcount[3] + pcount[5], 32'd0);

        // ---------------- bounce rejection on set ----------------
        clear_stats();
        for (int k = 0; k < 5; k++) begin
            set_raw = 1'b1;
            repeat (3) tick();
            set_raw = 1'b0;
            tick();
        end
        repeat (6) tick();
        check_eq("set_bounce_count", pcount[5], 32'd0);
        check_eq("set_bounce_held", {31'd0, o_held[5]}, 32'd0);
        set_raw = 1'b1;
        repeat (10) tick();
        check_eq("set_stable_count", pcount[5], 32'd1);
        check_eq("set_stable_held", {31'd0, o_held[5]}, 32'd1);
        set_raw = 1'b0;
        repeat (8) tick();

        // ---------------- auto-repeat on up ----------------
        clear_stats();
        up_raw = 1'b1;
        repeat (C_LAT) tick();
        p = cyc;
        check_eq("up_press", {31'd0, o_up}, 32'd1);
        // Raw falls so that the debounced release lands on edge P+30.
        repeat (24) tick();
        up_raw = 1'b0;
        repeat (20) tick();
        check_eq("up_count", up_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < up_q.size())
                check_eq($sformatf("up_rep%0d", i), up_q[i] - p, rep8[i]);
        end
        check_eq("up_held_after", {31'd0, o_held[0]}, 32'd0);

        // ---------------- simultaneous down + right ----------------
        // Down is released so the debounced release coincides with the
        // repeat pulse due at P+31, which must be suppressed.
        clear_stats();
        down_raw  = 1'b1;
        right_raw = 1'b1;
        repeat (C_LAT) tick();
        p = cyc;
        check_eq("sim_down_pulse",  {31'd0, o_down},  32'd1);
        check_eq("sim_right_pulse", {31'd0, o_right}, 32'd1);
        repeat (25) tick();
        down_raw  = 1'b0;
        right_raw = 1'b0;
        repeat (20) tick();
        check_eq("sim_down_first",  first_cyc[1], p);
        check_eq("sim_right_first", first_cyc[3], p);
        check_eq("sim_right_count", pcount[3], 32'd1);
        check_eq("sim_down_count", dn_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < dn_q.size())
                check_eq($sformatf("down_rep%0d", i), dn_q[i] - p, rep8[i]);
        end
        check_eq("sim_others", pcount[0] + pcount[2] + pcount[4] + pcount[5], 32'd0);

        // ---------------- no repeat on left ----------------
        clear_stats();
        left_raw = 1'b1;
        c0 = cyc;
        repeat (50) tick();
        left_raw = 1'b0;
        repeat (8) tick();
        check_eq("left_count", pcount[2], 32'd1);
        check_eq("left_latency", first_cyc[2] - c0, C_LAT);

        // ---------------- reset during DELAY ----------------
        clear_stats();
        up_raw = 1'b1;
        repeat (C_LAT) tick();
        check_eq("rst_up_press", {31'd0, o_up}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rst_async_pulses", {26'd0, pulses}, 32'd0);
        check_eq("rst_async_held",   {26'd0, o_held}, 32'd0);
        repeat (3) tick();
        clear_stats();
        rstn = 1'b1;
        c1 = cyc;
        repeat (20) tick();
        up_raw = 1'b0;
        repeat (15) tick();
        check_eq("rst_up_count", up_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < up_q.size())
                check_eq($sformatf("rst_up_rep%0d", i), up_q[i] - c1, rep5[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
